// File: rtl/eth_rx_filter.sv
// Ethernet RX filter: buffers header beats, forwards only NetTLP (IPv4/UDP, our IP, port window) frames.
// Optional macro ETH_RX_FILTER_STATS_EN adds pass_cnt/drop_cnt frame counters.
module eth_rx_filter #(
    parameter logic [31:0] LOCAL_IP      = 32'hC0A8_0A01,
    parameter logic [15:0] UDP_PORT_BASE = 16'h3000,
    parameter logic [15:0] UDP_PORT_MASK = 16'hF000,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic        eth_clk,
    input  logic        eth_rst,
    input  logic        eth_rx_tvalid,
    input  logic        eth_rx_tlast,
    input  logic [7:0]  eth_rx_tkeep,
    input  logic [63:0] eth_rx_tdata,
    input  logic        eth_rx_tuser,
    output logic        eth_out_tvalid,
    output logic        eth_out_tlast,
    output logic [7:0]  eth_out_tkeep,
    output logic [63:0] eth_out_tdata,
    output logic        eth_out_tuser,
    output logic        overflow
`ifdef ETH_RX_FILTER_STATS_EN
    ,
    output logic [31:0] pass_cnt,
    output logic [31:0] drop_cnt
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = 74;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {W_SYNC, W_HEAD, W_BODY} wr_state_t;
    typedef enum logic [1:0] {R_WAIT, R_PASS, R_DROP} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   d_count;
    logic [3:0]    vmem;
    logic [1:0]    v_wr, v_rd;
    logic [2:0]    v_count;
    logic [2:0]    beat_cnt;
    logic          match;

    logic          wr_req, d_full, d_push, d_lost, d_pop;
    logic [DW-1:0] rd_beat;
    logic          rd_last;
    logic          beat_ok, verdict_ok, v_push, v_bit, v_pop;

    assign d_full  = (d_count == FULL_CNT);
    assign wr_req  = eth_rx_tvalid && (wr_state != W_SYNC);
    assign d_push  = wr_req && !d_full;
    assign d_lost  = wr_req && d_full;
    assign d_pop   = (rd_state != R_WAIT) && (d_count != '0);
    assign rd_beat = mem[rd_ptr];
    assign rd_last = rd_beat[DW-1];

    // Header checks are folded into a running match flag, one beat at a time.
    always_comb begin
        beat_ok = 1'b1;
        case (beat_cnt)
            3'd1: beat_ok = (eth_rx_tdata[47:32] == 16'h0008) && (eth_rx_tdata[55:48] == 8'h45);
            3'd2: beat_ok = (eth_rx_tdata[63:56] == 8'h11);
            3'd3: beat_ok = ({eth_rx_tdata[55:48], eth_rx_tdata[63:56]} == LOCAL_IP[31:16]);
            3'd4: beat_ok = ({eth_rx_tdata[7:0], eth_rx_tdata[15:8]} == LOCAL_IP[15:0]) &&
                            (({eth_rx_tdata[39:32], eth_rx_tdata[47:40]} & UDP_PORT_MASK) == UDP_PORT_BASE);
            default: beat_ok = 1'b1;
        endcase
    end

    assign verdict_ok = ((beat_cnt == 3'd0) ? 1'b1 : match) && beat_ok;
    assign v_push     = d_push && (wr_state == W_HEAD) && ((beat_cnt == 3'd4) || eth_rx_tlast);
    assign v_bit      = (beat_cnt == 3'd4) && verdict_ok;
    assign v_pop      = (rd_state == R_WAIT) && (v_count != 3'd0);

    always_comb begin
        wr_next = wr_state;
        rd_next = rd_state;
        case (wr_state)
            W_SYNC: if (!eth_rx_tvalid || eth_rx_tlast) wr_next = W_HEAD;
            W_HEAD: begin
                if (d_lost)
                    wr_next = W_SYNC;
                else if (d_push && (beat_cnt == 3'd4) && !eth_rx_tlast)
                    wr_next = W_BODY;
            end
            W_BODY: begin
                if (d_lost)
                    wr_next = W_SYNC;
                else if (d_push && eth_rx_tlast)
                    wr_next = W_HEAD;
            end
            default: wr_next = W_SYNC;
        endcase
        case (rd_state)
            R_WAIT:         if (v_pop) rd_next = vmem[v_rd] ? R_PASS : R_DROP;
            R_PASS, R_DROP: if (d_pop && rd_last) rd_next = R_WAIT;
            default:        rd_next = R_WAIT;
        endcase
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            wr_state <= W_SYNC;
            rd_state <= R_WAIT;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_ff @(posedge eth_clk) begin
        if (d_push) mem[wr_ptr] <= {eth_rx_tlast, eth_rx_tuser, eth_rx_tkeep, eth_rx_tdata};
        if (v_push) vmem[v_wr] <= v_bit;
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            d_count        <= '0;
            v_wr           <= '0;
            v_rd           <= '0;
            v_count        <= '0;
            beat_cnt       <= '0;
            match          <= 1'b0;
            overflow       <= 1'b0;
            eth_out_tvalid <= 1'b0;
            eth_out_tlast  <= 1'b0;
            eth_out_tuser  <= 1'b0;
            eth_out_tkeep  <= '0;
            eth_out_tdata  <= '0;
        end else begin
            if (d_push) wr_ptr <= wr_ptr + AW'(1);
            if (d_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({d_push, d_pop})
                2'b10:   d_count <= d_count + CNT_ONE;
                2'b01:   d_count <= d_count - CNT_ONE;
                default: d_count <= d_count;
            endcase
            if (v_push) v_wr <= v_wr + 2'd1;
            if (v_pop)  v_rd <= v_rd + 2'd1;
            case ({v_push, v_pop})
                2'b10:   v_count <= v_count + 3'd1;
                2'b01:   v_count <= v_count - 3'd1;
                default: v_count <= v_count;
            endcase
            if (wr_state != W_HEAD)
                beat_cnt <= '0;
            else if (d_push)
                beat_cnt <= (eth_rx_tlast || (beat_cnt == 3'd4)) ? 3'd0 : beat_cnt + 3'd1;
            if ((wr_state == W_HEAD) && d_push) match <= verdict_ok;
            overflow       <= overflow | d_lost;
            eth_out_tvalid <= (rd_state == R_PASS) && d_pop;
            if ((rd_state == R_PASS) && d_pop) begin
                eth_out_tlast <= rd_beat[73];
                eth_out_tuser <= rd_beat[72];
                eth_out_tkeep <= rd_beat[71:64];
                eth_out_tdata <= rd_beat[63:0];
            end else begin
                eth_out_tlast <= 1'b0;
                eth_out_tuser <= 1'b0;
                eth_out_tkeep <= '0;
                eth_out_tdata <= '0;
            end
        end
    end

`ifdef ETH_RX_FILTER_STATS_EN
    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
        end else if (v_push) begin
            if (v_bit) pass_cnt <= pass_cnt + 32'd1;
            else       drop_cnt <= drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_filter.sv
// Directed self-checking bench for eth_rx_filter: forwarded beats, latency, drops, runts, tuser, reset mid-frame.
module tb_eth_rx_filter;

    logic        eth_clk = 1'b0;
    logic        eth_rst;
    logic        eth_rx_tvalid, eth_rx_tlast, eth_rx_tuser;
    logic [7:0]  eth_rx_tkeep;
    logic [63:0] eth_rx_tdata;
    logic        eth_out_tvalid, eth_out_tlast, eth_out_tuser;
    logic [7:0]  eth_out_tkeep;
    logic [63:0] eth_out_tdata;
    logic        overflow;
`ifdef ETH_RX_FILTER_STATS_EN
    logic [31:0] pass_cnt, drop_cnt;
`endif

    always #5 eth_clk = ~eth_clk;

    eth_rx_filter #(
        .LOCAL_IP      (32'hC0A8_0A01),
        .UDP_PORT_BASE (16'h3000),
        .UDP_PORT_MASK (16'hF000),
        .FIFO_DEPTH    (16)
    ) dut (
        .eth_clk        (eth_clk),
        .eth_rst        (eth_rst),
        .eth_rx_tvalid  (eth_rx_tvalid),
        .eth_rx_tlast   (eth_rx_tlast),
        .eth_rx_tkeep   (eth_rx_tkeep),
        .eth_rx_tdata   (eth_rx_tdata),
        .eth_rx_tuser   (eth_rx_tuser),
        .eth_out_tvalid (eth_out_tvalid),
        .eth_out_tlast  (eth_out_tlast),
        .eth_out_tkeep  (eth_out_tkeep),
        .eth_out_tdata  (eth_out_tdata),
        .eth_out_tuser  (eth_out_tuser),
        .overflow       (overflow)
`ifdef ETH_RX_FILTER_STATS_EN
        ,
        .pass_cnt       (pass_cnt),
        .drop_cnt       (drop_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic        last;
        logic        user;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    localparam logic [31:0] OUR_IP = 32'hC0A8_0A01;

    logic [31:0] cyc = '0;
    int unsigned tests = 0;
    int unsigned fails = 0;
    beat_t exp_q[$];
    beat_t got_q[$];

    always @(posedge eth_clk) cyc <= cyc + 32'd1;

    // Output beats are timestamped with the index of the edge that registered them.
    always @(negedge eth_clk) begin : capture
        beat_t b;
        if (eth_out_tvalid === 1'b1) begin
            b.cyc  = cyc;
            b.last = eth_out_tlast;
            b.user = eth_out_tuser;
            b.keep = eth_out_tkeep;
            b.data = eth_out_tdata;
            got_q.push_back(b);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] make_beat(input int unsigned seed, input int unsigned k,
                                              input logic [31:0] ip, input logic [15:0] dport,
                                              input logic [15:0] etype);
        logic [63:0] r;
        logic [7:0]  v;
        int unsigned idx;
        r = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            idx = 8 * k + j;
            v = 8'((seed * 37 + idx * 5 + 1) & 255);
            case (idx)
                12: v = etype[15:8];
                13: v = etype[7:0];
                14: v = 8'h45;
                23: v = 8'h11;
                30: v = ip[31:24];
                31: v = ip[23:16];
                32: v = ip[15:8];
                33: v = ip[7:0];
                36: v = dport[15:8];
                37: v = dport[7:0];
                default: ;
            endcase
            r[j*8 +: 8] = v;
        end
        return r;
    endfunction

    // Drives beats k0..k1 of an n-beat frame, one per cycle, starting and ending on a negedge.
    task automatic send_part(input int unsigned seed, input int unsigned n, input int unsigned k0,
                             input int unsigned k1, input logic [31:0] ip, input logic [15:0] dport,
                             input logic [15:0] etype, input logic bad, input logic pass);
        beat_t b;
        for (int unsigned k = k0; k <= k1; k++) begin
            eth_rst       = 1'b0;
            eth_rx_tvalid = 1'b1;
            eth_rx_tlast  = (k == n - 1);
            eth_rx_tuser  = bad && (k == n - 1);
            eth_rx_tkeep  = (k == n - 1) ? 8'h3F : 8'hFF;
            eth_rx_tdata  = make_beat(seed, k, ip, dport, etype);
            if (pass) begin
                b.cyc  = cyc + 32'd7;
                b.last = eth_rx_tlast;
                b.user = eth_rx_tuser;
                b.keep = eth_rx_tkeep;
                b.data = eth_rx_tdata;
                exp_q.push_back(b);
            end
            @(negedge eth_clk);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            eth_rst       = 1'b0;
            eth_rx_tvalid = 1'b0;
            eth_rx_tlast  = 1'b0;
            eth_rx_tuser  = 1'b0;
            eth_rx_tkeep  = '0;
            eth_rx_tdata  = '0;
            @(negedge eth_clk);
        end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_beat"}, 128'(got_q[i]), 128'(exp_q[i]));
        chk({tag, "_overflow"}, 128'(overflow), 128'(0));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        eth_rst       = 1'b1;
        eth_rx_tvalid = 1'b0;
        eth_rx_tlast  = 1'b0;
        eth_rx_tuser  = 1'b0;
        eth_rx_tkeep  = '0;
        eth_rx_tdata  = '0;
        repeat (3) @(negedge eth_clk);
        chk("rst_tvalid", 128'(eth_out_tvalid), 128'(0));
        chk("rst_tlast", 128'(eth_out_tlast), 128'(0));
        chk("rst_tkeep", 128'(eth_out_tkeep), 128'(0));
        chk("rst_tdata", 128'(eth_out_tdata), 128'(0));
        chk("rst_tuser", 128'(eth_out_tuser), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
`ifdef ETH_RX_FILTER_STATS_EN
        chk("rst_pass_cnt", 128'(pass_cnt), 128'(0));
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
`endif
        idle(3);
        got_q.delete();

        // Valid 8-beat frame
        send_part(1, 8, 0, 7, OUR_IP, 16'h3000, 16'h0800, 1'b0, 1'b1);
        idle(20);
        check_stream("valid8");
`ifdef ETH_RX_FILTER_STATS_EN
        chk("valid8_pass_cnt", 128'(pass_cnt), 128'(1));
`endif

        // Foreign frames: wrong port, wrong IP, ARP
        send_part(2, 8, 0, 7, OUR_IP, 16'h4000, 16'h0800, 1'b0, 1'b0);
        idle(1);
        send_part(3, 8, 0, 7, 32'hC0A8_0A02, 16'h3000, 16'h0800, 1'b0, 1'b0);
        idle(1);
        send_part(4, 8, 0, 7, OUR_IP, 16'h3000, 16'h0806, 1'b0, 1'b0);
        idle(20);
        check_stream("foreign");
`ifdef ETH_RX_FILTER_STATS_EN
        chk("foreign_drop_cnt", 128'(drop_cnt), 128'(3));
`endif

        // Runt followed immediately by a valid 6-beat frame
        send_part(5, 3, 0, 2, OUR_IP, 16'h3000, 16'h0800, 1'b0, 1'b0);
        send_part(6, 6, 0, 5, OUR_IP, 16'h3ABC, 16'h0800, 1'b0, 1'b1);
        idle(20);
        check_stream("runt");
`ifdef ETH_RX_FILTER_STATS_EN
        chk("runt_drop_cnt", 128'(drop_cnt), 128'(4));
        chk("runt_pass_cnt", 128'(pass_cnt), 128'(2));
`endif

        // Bad-CRC matching frame is forwarded with tuser on its last beat
        send_part(7, 8, 0, 7, OUR_IP, 16'h3001, 16'h0800, 1'b1, 1'b1);
        idle(20);
        check_stream("tuser");

        // 20 frames with one idle cycle between each
        for (int unsigned f = 0; f < 20; f++) begin
            send_part(10 + f, 8, 0, 7, OUR_IP, 16'h3000 + 16'(f), 16'h0800, 1'b0, 1'b1);
            idle(1);
        end
        idle(30);
        check_stream("burst20");
`ifdef ETH_RX_FILTER_STATS_EN
        chk("burst20_pass_cnt", 128'(pass_cnt), 128'(23));
`endif

        // Reset on beat 3 of a valid frame, then a normal frame
        send_part(40, 8, 0, 2, OUR_IP, 16'h3000, 16'h0800, 1'b0, 1'b0);
        eth_rst       = 1'b1;
        eth_rx_tvalid = 1'b1;
        eth_rx_tlast  = 1'b0;
        eth_rx_tuser  = 1'b0;
        eth_rx_tkeep  = 8'hFF;
        eth_rx_tdata  = make_beat(40, 3, OUR_IP, 16'h3000, 16'h0800);
        @(negedge eth_clk);
        chk("midrst_tvalid", 128'(eth_out_tvalid), 128'(0));
        chk("midrst_tdata", 128'(eth_out_tdata), 128'(0));
        chk("midrst_overflow", 128'(overflow), 128'(0));
        send_part(40, 8, 4, 7, OUR_IP, 16'h3000, 16'h0800, 1'b0, 1'b0);
        idle(1);
        send_part(41, 8, 0, 7, OUR_IP, 16'h3FFF, 16'h0800, 1'b0, 1'b1);
        idle(20);
        check_stream("midrst");
`ifdef ETH_RX_FILTER_STATS_EN
        chk("midrst_pass_cnt", 128'(pass_cnt), 128'(1));
        chk("midrst_drop_cnt", 128'(drop_cnt), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
